// File: rtl/swap_pkg.sv
// Shared definitions for the swap loader and the three-register swap unit.
package swap_pkg;

  localparam int SWAP_N   = 8;
  localparam int SWAP_LAT = 3;

  typedef enum logic [2:0] {
    L1   = 3'd0,
    L2   = 3'd1,
    L3   = 3'd2,
    KICK = 3'd3,
    WAIT = 3'd4
  } swap_state_t;

endpackage

// File: rtl/swap_loader.sv
// Loads three words into the swap unit over the external bus, starts the swap,
// then waits for Done with a timeout and counts completed swaps.
module swap_loader
  import swap_pkg::*;
#(
  parameter int N       = SWAP_N,
  parameter int TIMEOUT = 8
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic [N-1:0] Data,
  output logic         Extern,
  output logic         RinExt1,
  output logic         RinExt2,
  output logic         RinExt3,
  output logic         w,
  input  logic         Done,
  output logic         swap_done,
  output logic         timeout,
  output logic [7:0]   swap_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  swap_state_t    state, nxt;
  logic [TW-1:0]  tcnt;
  logic           ok, expire;

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    Extern   = 1'b0;
    Data     = '0;
    RinExt1  = 1'b0;
    RinExt2  = 1'b0;
    RinExt3  = 1'b0;
    w        = 1'b0;
    ok       = 1'b0;
    expire   = 1'b0;
    case (state)
      L1, L2, L3: begin
        in_ready = 1'b1;
        if (in_valid) begin
          Extern = 1'b1;
          Data   = in_data;
          case (state)
            L1:      begin RinExt1 = 1'b1; nxt = L2;   end
            L2:      begin RinExt2 = 1'b1; nxt = L3;   end
            default: begin RinExt3 = 1'b1; nxt = KICK; end
          endcase
        end
      end
      KICK: begin
        w   = 1'b1;
        nxt = WAIT;
      end
      WAIT: begin
        // Done on the final allowed cycle still counts as success
        if (Done) begin
          ok  = 1'b1;
          nxt = L1;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          expire = 1'b1;
          nxt    = L1;
        end
      end
      default: nxt = L1;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= L1;
      tcnt       <= '0;
      swap_done  <= 1'b0;
      timeout    <= 1'b0;
      swap_count <= '0;
    end else begin
      state     <= nxt;
      swap_done <= ok;
      timeout   <= expire;
      if (state != WAIT)
        tcnt <= '0;
      else if (!Done)
        tcnt <= tcnt + TW'(1);
      if (ok)
        swap_count <= swap_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_swap_loader.sv
// Self-checking bench for swap_loader with a behavioural swap-unit stub.
module tb_swap_loader;
  import swap_pkg::*;

  localparam int N  = 8;
  localparam int TO = 8;

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] in_data = '0;
  logic         in_ready, Extern, RinExt1, RinExt2, RinExt3, w, Done;
  logic [N-1:0] Data;
  logic         swap_done, timeout;
  logic [7:0]   swap_count;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  swap_loader #(.N(N), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .Data(Data), .Extern(Extern), .RinExt1(RinExt1),
    .RinExt2(RinExt2), .RinExt3(RinExt3), .w(w), .Done(Done),
    .swap_done(swap_done), .timeout(timeout), .swap_count(swap_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Swap unit stub: busy for lat cycles after sampling w, Done in the last one,
  // then rotates R1<-R2<-R3<-R1. "dead" models a unit that never answers.
  int           scnt;
  int           lat = SWAP_LAT;
  bit           dead = 1'b0;
  logic [N-1:0] r1, r2, r3;
  assign Done = (scnt != 0) && (scnt == lat);

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      scnt <= 0; r1 <= '0; r2 <= '0; r3 <= '0;
    end else begin
      if (Extern && RinExt1) r1 <= Data;
      if (Extern && RinExt2) r2 <= Data;
      if (Extern && RinExt3) r3 <= Data;
      if (scnt == 0) begin
        if (w && !dead) scnt <= 1;
      end else if (scnt == lat) begin
        r1 <= r2; r2 <= r3; r3 <= r1; scnt <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end
  end

  // Behavioural reference: words held so far, whether the start pulse is due,
  // how long we have been waiting, and pending one-cycle result pulses.
  int m_loaded, m_waited, m_count;
  bit m_kick, m_wait, m_pd, m_pt;

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      m_loaded = 0; m_waited = 0; m_count = 0;
      m_kick = 0; m_wait = 0; m_pd = 0; m_pt = 0;
    end else begin
      m_pd = 0; m_pt = 0;
      if (m_kick) begin
        m_kick = 0; m_wait = 1; m_waited = 0;
      end else if (m_wait) begin
        m_waited++;
        if (Done) begin
          m_pd = 1; m_count = (m_count + 1) % 256; m_wait = 0; m_loaded = 0;
        end else if (m_waited == TO) begin
          m_pt = 1; m_wait = 0; m_loaded = 0;
        end
      end else if (in_valid) begin
        m_loaded++;
        if (m_loaded == 3) m_kick = 1;
      end
    end
  end

  function automatic bit loading();
    return !m_kick && !m_wait;
  endfunction

  int cyc = 0, first_idx = 0, w_idx = 0, to_idx = 0, sd_idx = 0, n_sd = 0;

  always @(negedge Clock) begin
    bit acc;
    cyc++;
    acc = loading() && in_valid;
    chk("in_ready", in_ready, loading());
    chk("Extern", Extern, acc);
    chk("Data", Data, acc ? in_data : '0);
    chk("RinExt", {RinExt3, RinExt2, RinExt1}, acc ? (3'b001 << m_loaded) : 3'b000);
    chk("w", w, m_kick);
    chk("swap_done", swap_done, m_pd);
    chk("timeout", timeout, m_pt);
    chk("swap_count", swap_count, m_count);
    chk("no_contention", Extern && (scnt != 0), 1'b0);
    if (acc && m_loaded == 0) first_idx = cyc;
    if (w) w_idx = cyc;
    if (timeout) to_idx = cyc;
    if (swap_done) begin sd_idx = cyc; n_sd++; end
  end

  task automatic word(input logic [N-1:0] d);
    in_valid = 1'b1; in_data = d;
    @(posedge Clock); #1;
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic load3(input logic [N-1:0] a, b, c, input int gap);
    word(a);
    repeat (gap) begin @(posedge Clock); #1; end
    word(b);
    repeat (gap) begin @(posedge Clock); #1; end
    word(c);
  endtask

  task automatic wait_ready();
    int k = 0;
    @(posedge Clock); #1;
    while (!loading() && k < 40) begin @(posedge Clock); #1; k++; end
    if (k >= 40) chk("wait_ready_timeout", 1, 0);
    @(posedge Clock); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, k, d0;
    // Reset state
    repeat (3) @(posedge Clock);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_extern", Extern, 0);
    chk("rst_count", swap_count, 0);
    Resetn = 1'b1;

    // Back-to-back load: swap_done six edges after the first accept edge
    load3(8'h11, 8'h22, 8'h33, 0);
    wait_ready();
    chk("b2b_latency", sd_idx - first_idx, 7);
    chk("b2b_r1", r1, 8'h22);
    chk("b2b_r2", r2, 8'h33);
    chk("b2b_r3", r3, 8'h11);
    chk("b2b_count", swap_count, 1);

    // Five-cycle gaps between words
    load3(8'h44, 8'h55, 8'h66, 5);
    wait_ready();
    chk("gap_latency", sd_idx - first_idx, 17);
    chk("gap_r1", r1, 8'h55);
    chk("gap_r2", r2, 8'h66);
    chk("gap_r3", r3, 8'h44);
    chk("gap_count", swap_count, 2);

    // Done never arrives: eight WAIT cycles then a timeout pulse
    dead = 1'b1;
    load3(8'h01, 8'h02, 8'h03, 0);
    wait_ready();
    chk("to_delay", to_idx - w_idx, 9);
    chk("to_count", swap_count, 2);
    chk("to_back_l1", in_ready, 1);
    dead = 1'b0;

    // Done on the last permitted WAIT cycle is a success
    lat = TO;
    load3(8'h07, 8'h08, 8'h09, 0);
    wait_ready();
    chk("edge_delay", sd_idx - w_idx, 9);
    chk("edge_count", swap_count, 3);
    chk("edge_r1", r1, 8'h08);
    lat = SWAP_LAT;

    // Reset while waiting, then a fresh load
    load3(8'hA1, 8'hA2, 8'hA3, 0);
    @(posedge Clock); #1;
    @(negedge Clock); #2;
    Resetn = 1'b0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_outs", {Extern, RinExt3, RinExt2, RinExt1, w, swap_done, timeout}, 0);
    chk("mid_rst_data", Data, 0);
    chk("mid_rst_count", swap_count, 0);
    @(negedge Clock); #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
    load3(8'hB1, 8'hB2, 8'hB3, 0);
    wait_ready();
    chk("post_rst_r1", r1, 8'hB2);
    chk("post_rst_r3", r3, 8'hB1);
    chk("post_rst_count", swap_count, 1);

    // 256 random swaps: counter must wrap back to its starting value
    base = m_count;
    d0 = n_sd;
    k = 0;
    while (n_sd - d0 < 256 && k < 20000) begin
      if (loading()) lat = $urandom_range(3, TO);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = N'($urandom);
      @(posedge Clock); #1;
      k++;
    end
    in_valid = 1'b0;
    if (k >= 20000) chk("rand_budget", 1, 0);
    wait_ready();
    chk("wrap_count", swap_count, base[7:0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swap_loader.md
# swap_loader

Upstream sequencer for the three-register bus swap unit. Accepts three N-bit words over a valid/ready stream and writes them into R1, R2, R3 through the swap unit's external tri-state driver (`Data`/`Extern`/`RinExtN`). It then pulses `w` to start the swap, waits for `Done`, and reports completion or timeout. It is the only agent driving `Extern`/`RinExt*`, so it owns bus arbitration against the swap FSM.

## Interface
- `N`, 8: data/bus width; must match the swap unit's `n`.
- `TIMEOUT`, 8: maximum number of `WAIT` cycles without `Done` before an error; must be ≥ 4.
- `Clock`  in  1  the single clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset; shared with the swap unit.
- `in_valid`  in  1  an upstream word is present.
- `in_data`  in  N  the upstream word.
- `in_ready`  out  1  loader accepts a word this cycle.
- `Data`  out  N  word driven toward the swap unit's external tri-state.
- `Extern`  out  1  enables the external tri-state onto `BusWires`.
- `RinExt1`, `RinExt2`, `RinExt3`  out  1 each  load enables for R1, R2, R3.
- `w`  out  1  swap start; one-cycle pulse.
- `Done`  in  1  swap unit's completion flag.
- `swap_done`  out  1  registered one-cycle pulse: swap completed.
- `timeout`  out  1  registered one-cycle pulse: `Done` did not arrive in time.
- `swap_count`  out  8  completed swaps, wraps 255→0.

## Operation
- States: `L1`, `L2`, `L3`, `KICK`, `WAIT`. Reset state is `L1`.
- In `L1`/`L2`/`L3`:
  - `in_ready`=1.
  - On an accepted word (`in_valid`&`in_ready`): `Extern`=1, `Data`=`in_data`, and `RinExtK`=1 for the current state K. All combinational in the same cycle.
  - Transitions: L1→L2→L3→`KICK` on acceptance; hold otherwise.
- With no accepted word: `Extern`=0, `RinExt*`=0, and `Data`=0 (zeroed, not X).
- `KICK`: `w`=1 for exactly this cycle, `in_ready`=0. Unconditional →`WAIT`.
- `WAIT`:
  - `in_ready`=0 and `Extern`=0; the bus belongs to the swap FSM.
  - Counter `tcnt` (width $clog2(TIMEOUT+1)) is cleared on entry and increments each `WAIT` cycle without `Done`.
  - `Done`=1: →`L1`, `swap_done` pulse next cycle, `swap_count`+1.
  - `Done`=0 and `tcnt`==TIMEOUT-1: →`L1`, `timeout` pulse next cycle, `swap_count` unchanged.
  - `Done`=1 in the same cycle as the timeout condition counts as success.
- `Done` is ignored outside `WAIT`.
- Reset values:
  - State `L1`; `tcnt`, `swap_count`, `swap_done`, `timeout` = 0.
  - In the `L1` reset state: `in_ready`=1, all other outputs 0.
- Reset mid-operation (any state) returns to `L1` immediately, with partial loads abandoned. The swap unit resets on the same `Resetn`.

## Timing
- Let e1, e2, e3 be the edges accepting words 1–3 back-to-back.
  - `KICK` occupies e3–e4, and the swap unit samples `w` at e4.
  - Swap states: B at e4–e5, C at e5–e6, D (`Done`) at e6–e7.
  - The loader leaves `WAIT` at e7; `swap_done` is high e7–e8.
  - `in_ready` returns to 1 at e7, so the next first word can be accepted at e8.
- Minimum period per swap is 7 cycles.
- `Extern` is never 1 while the swap FSM is in B/C/D. This no-contention rule must hold.
- Upstream stalls (`in_valid`=0) stretch `L1`–`L3` arbitrarily with no timeout.

## Structure
- Shared package `swap_pkg`:
  - state encoding localparams (`L1`=0, `L2`=1, `L3`=2, `KICK`=3, `WAIT`=4, 3 bits);
  - default width `SWAP_N`=8;
  - `SWAP_LAT`=3, the swap unit's w-to-`Done` latency.
- No sub-module is needed. Implement as one FSM with a timeout counter and a completion counter.

## Test plan
- Reset, then words 0x11, 0x22, 0x33 on consecutive cycles:
  - `RinExt1`/`RinExt2`/`RinExt3` each high one cycle with matching `Data`;
  - `w` high one cycle later;
  - `swap_done` 6 cycles after the first accept;
  - R1=0x22, R2=0x33, R3=0x11 in the swap unit;
  - `swap_count`=1.
- `in_valid` gaps of 5 cycles between words: state holds, no `Extern` during gaps, and the swap completes identically.
- Stub `Done` tied to 0: `timeout` pulses after 8 `WAIT` cycles, state returns to `L1`, and `swap_count` is unchanged.
- Assert `Resetn` low during `WAIT` (after word 3): all outputs return to reset values immediately, and a fresh 3-word load then completes normally.
- 256 consecutive swaps: `swap_count` wraps to 0. Check `Extern`&(swap FSM ≠ A) is never true.
